// File: rtl/pack_ct_pkg.sv
// Shared constants for the ciphertext packer: scheme parameters, word width
// and the controller state encodings.
package pack_ct_pkg;

  localparam int N      = 256;
  localparam int EQ     = 13;
  localparam int EP     = 10;
  localparam int ET     = 4;
  localparam int H1     = 4;
  localparam int WORD_W = 64;

  localparam int LANES   = WORD_W / 16;
  localparam int V_WORDS = N / LANES;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_FETCH_M = 4'd1;
  localparam logic [3:0] ST_LOAD_M  = 4'd2;
  localparam logic [3:0] ST_LOAD_V  = 4'd3;
  localparam logic [3:0] ST_COMP    = 4'd4;
  localparam logic [3:0] ST_STORE   = 4'd5;
  localparam logic [3:0] ST_DONE    = 4'd15;

endpackage

// File: rtl/cm_round.sv
// One coefficient lane: add the rounding constant, subtract the message bit
// at weight 2^(EP-1), wrap to EP bits and keep the top ET bits.
module cm_round
  import pack_ct_pkg::*;
(
  input  logic [EP-1:0] v,
  input  logic          m,
  output logic [ET-1:0] cm
);

  logic [EP-1:0] sum;

  assign sum = v + EP'(H1) - {m, {(EP-1){1'b0}}};
  assign cm  = sum[EP-1:EP-ET];

endmodule

// File: rtl/pack_ct.sv
// Ciphertext packer: streams v and message words from memory, rounds four
// coefficients per v word and writes sixteen packed 64-bit words.
module pack_ct
  import pack_ct_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              read_base_sel,
  output logic [8:0]        read_address,
  input  logic [WORD_W-1:0] read_data,
  output logic [8:0]        write_address,
  output logic [WORD_W-1:0] write_data,
  output logic              write_en,
  output logic              done
);

  logic [3:0]        state;
  logic [3:0]        state_next;
  logic [8:0]        v_address;
  logic [WORD_W-1:0] v_buffer;
  logic [WORD_W-1:0] m_buffer;
  logic [WORD_W-1:0] c_buffer;
  logic [ET-1:0]     cm [LANES];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    cm_round u_cm_round (
      .v  (v_buffer[16*j +: EP]),
      .m  (m_buffer[j]),
      .cm (cm[j])
    );
  end

  // The top six bits of each 16-bit v lane carry no coefficient data.
  logic unused_v_bits;
  assign unused_v_bits = ^{v_buffer[63:58], v_buffer[47:42],
                           v_buffer[31:26], v_buffer[15:10]};

  // NOTE: every output gets a default before the case, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE:    state_next = ST_FETCH_M;
      ST_FETCH_M: state_next = ST_LOAD_M;
      ST_LOAD_M:  state_next = ST_LOAD_V;
      ST_LOAD_V:  state_next = ST_COMP;
      ST_COMP:    state_next = (v_address[1:0] == 2'd0) ? ST_STORE : ST_LOAD_V;
      ST_STORE: begin
        if (v_address == 9'(V_WORDS))
          state_next = ST_DONE;
        else if (v_address[3:0] == 4'd0)
          state_next = ST_FETCH_M;
        else
          state_next = ST_LOAD_V;
      end
      ST_DONE:    state_next = ST_DONE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Memory has one cycle of read latency, so the address presented in a state
  // is consumed by the state that follows it.
  always_comb begin
    read_base_sel = (state == ST_FETCH_M);
    read_address  = read_base_sel ? {4'd0, v_address[8:4]} : v_address;
    write_en      = (state == ST_STORE);
    done          = (state == ST_DONE);
    write_data    = c_buffer;
  end

  // NOTE: non-blocking assignments keep every register update based on the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      v_address     <= '0;
      write_address <= '0;
    end else begin
      state <= state_next;
      if (state == ST_LOAD_V)
        v_address <= v_address + 9'd1;
      if (state == ST_STORE)
        write_address <= write_address + 9'd1;
    end
  end

  // NOTE: the data buffers are deliberately left without reset; each one is
  // loaded before it is read, and omitting reset keeps them plain flops.
  always_ff @(posedge clk) begin
    case (state)
      ST_LOAD_M: m_buffer <= read_data;
      ST_LOAD_V: v_buffer <= read_data;
      ST_COMP: begin
        c_buffer <= {cm[3], cm[2], cm[1], cm[0], c_buffer[WORD_W-1:16]};
        m_buffer <= m_buffer >> LANES;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/pack_ct.md
PACK_CT -- requirements
Module: pack_ct

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: clk (all state on rising edge), rst (synchronous, active-high).
REQ-002 SHALL have ports:
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 read_base_sel  out  1  read source select; 1 = message, 0 = v
 read_address  out  9  read word address
 read_data  in  64  read word, valid the cycle after address is presented
 write_address  out  9  ciphertext word address
 write_data  out  64  packed ciphertext word
 write_en  out  1  write strobe, one cycle per word
 done  out  1  completion flag, sticky until rst
REQ-003 SHALL take v as 64 words, 4 coefficients per word; coefficient 4w+j in bits [16j+9:16j], bits [16j+15:16j+10] ignored.
REQ-004 SHALL take the message as 4 words; bit i of the message is m word i/64, bit i%64.
REQ-005 SHALL emit 16 output words; word k bits [4j+3:4j] hold cm[16k+j], j=0..15.

Function
REQ-006 SHALL compute cm[i] = ((v[i] + H1 - (m[i] << 9)) mod 1024) >> 6, with H1 = 4; 10-bit wrap, 4-bit result.
REQ-007 SHALL compute 4 lanes in parallel from a 64-bit v buffer and the low 4 bits of a 64-bit m buffer.
REQ-008 SHALL keep a 9-bit v_address counter, reset to 0, that increments once per v word loaded.
REQ-009 SHALL drive read_address = v_address when read_base_sel=0 and {4'd0, v_address[8:4]} when read_base_sel=1.
REQ-010 SHALL implement states IDLE(0), FETCH_M(1), LOAD_M(2), LOAD_V(3), COMP(4), STORE(5) and DONE(15); any other encoding goes to IDLE.
REQ-011 IDLE -> FETCH_M unconditionally; no start input; the block runs once after each reset.
REQ-012 FETCH_M: read_base_sel=1; -> LOAD_M.
REQ-013 LOAD_M: m_buffer <= read_data; read_base_sel=0; -> LOAD_V.
REQ-014 LOAD_V: v_buffer <= read_data; v_address increments; -> COMP.
REQ-015 COMP: c_buffer <= {cm3,cm2,cm1,cm0,c_buffer[63:16]}; m_buffer shifts right by 4; -> STORE if v_address[1:0]==0, else LOAD_V.
REQ-016 STORE: write_en=1 and write_address increments after the write; -> DONE if v_address==64, else FETCH_M if v_address[3:0]==0, else LOAD_V.
REQ-017 DONE: holds with done=1; no further reads or writes.
REQ-018 write_data SHALL equal c_buffer combinationally; it is meaningful only while write_en=1.
REQ-019 Total run: 152 cycles in states 1-5; done rises on the 153rd rising edge after the first edge with rst low.
REQ-020 Exactly 16 writes SHALL occur, to addresses 0..15 in order; 4 message reads (addresses 0..3) and 64 v reads (addresses 0..63).

Reset
REQ-021 rst SHALL force state=IDLE, v_address=0 and write_address=0. Resulting outputs: read_base_sel=0, read_address=0, write_en=0, done=0.
REQ-022 v_buffer, m_buffer and c_buffer SHALL NOT be reset; write_data is undefined until the first COMP.
REQ-023 rst asserted mid-operation SHALL abort the run; after release the block restarts a full run from word 0.

Structure
REQ-024 A shared package SHALL hold N=256, EQ=13, EP=10, ET=4, H1=4, the 64-bit word width and the state encodings.
REQ-025 A combinational sub-module cm_round (10-bit v, 1-bit m -> 4-bit cm) SHALL be instantiated four times; everything else stays in pack_ct.

Verification
REQ-026 v=0, m=0 -> all 16 writes = 64'h0; done after 153 edges.
REQ-027 v=960 (0x3C0) in every lane, m=0 -> all writes = 64'hFFFF_FFFF_FFFF_FFFF.
REQ-028 v=0, m all ones -> cm=(4-512) mod 1024 >> 6 = 8 -> all writes = 64'h8888_8888_8888_8888.
REQ-029 v[i]=64*(i mod 16), bits [15:10] of each lane = 6'h3F, m=0 -> every write = 64'hFEDC_BA98_7654_3210 (checks lane order and that upper bits are ignored).
REQ-030 v=508, m all ones -> wrap to 0 -> all writes 0. Random vectors are checked against a software model.
REQ-031 rst pulsed for one cycle at edge 60 -> write_address returns to 0, 16 fresh writes to addresses 0..15, done 153 edges after release.
